// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer that shares one combinational ALU: IDLE accepts a request, EXEC drives the ALU, RESP returns the result.
// Optional ALU_ARB_FIXED_PRIO_EN: port 0 always wins a tie; otherwise ties are round-robin on last_grant.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp_f,
   output logic        resp_zf,
   output logic        resp_of,
   output logic [2:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_f,
   input  logic [31:0] alu_zf,
   input  logic [31:0] alu_of,
   output logic [1:0]  dbg_state
);

   // Handshakes: a request transfers on the cycle req*_valid & req*_ready are both high; a
   // response is consumed when resp*_valid & resp*_ready are both high. Valid never waits on ready.
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        owner;
   logic        last_grant;
   logic        gnt0, gnt1;
   logic        hs;
   logic        resp_done;
   logic        unused_ok;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
         gnt0 = last_grant;
         gnt1 = ~last_grant;
      end else begin
         gnt0 = req0_valid;
         gnt1 = req1_valid;
      end
`endif
   end

   assign hs        = (state == IDLE) && (gnt0 || gnt1);
   assign resp_done = (state == RESP) && (owner ? resp1_ready : resp0_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is gated by rst_n so both ports see 0 while reset is held.
   always_comb begin
      req0_ready  = rst_n && (state == IDLE) && gnt0;
      req1_ready  = rst_n && (state == IDLE) && gnt1;
      resp0_valid = (state == RESP) && !owner;
      resp1_valid = (state == RESP) && owner;
      alu_op      = op_q;
      alu_a       = a_q;
      alu_b       = b_q;
      dbg_state   = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= 3'b000;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         resp_f     <= 32'd0;
         resp_zf    <= 1'b0;
         resp_of    <= 1'b0;
      end else begin
         if (hs) begin
            op_q       <= gnt1 ? req1_op : req0_op;
            a_q        <= gnt1 ? req1_a  : req0_a;
            b_q        <= gnt1 ? req1_b  : req0_b;
            owner      <= gnt1;
            last_grant <= gnt1;
         end
         // SLT leaves the ALU's OF stale, so it is forced low here.
         if (state == EXEC) begin
            resp_f  <= alu_f;
            resp_zf <= alu_zf[0];
            resp_of <= (op_q == 3'b110) ? 1'b0 : alu_of[0];
         end
      end
   end

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign unused_ok = ^{alu_zf[31:1], alu_of[31:1], last_grant};
`else
   assign unused_ok = ^{alu_zf[31:1], alu_of[31:1]};
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

   logic        clk, rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [31:0] resp_f;
   logic        resp_zf, resp_of;
   logic [2:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_f, alu_zf, alu_of;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: one transaction in flight, expected results in a queue.
   logic [33:0] exp_q[$];
   bit          m_busy, m_owner, m_last, m_in_resp;
   logic [2:0]  m_op;
   logic [31:0] m_a, m_b;
   bit          acc0, acc1;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_f(resp_f), .resp_zf(resp_zf), .resp_of(resp_of),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {overflow, result} of the real ALU; shift amount comes from A.
   function automatic logic [32:0] alu_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] f;
      logic        of;
      of = 1'b0;
      case (op)
         3'd0: f = a & b;
         3'd1: f = a | b;
         3'd2: f = a ^ b;
         3'd3: f = ~(a | b);
         3'd4: begin f = a + b; of = (a[31] == b[31]) && (f[31] != a[31]); end
         3'd5: begin f = a - b; of = (a[31] != b[31]) && (f[31] != a[31]); end
         3'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: f = b << a[4:0];
      endcase
      return {of, f};
   endfunction

   // ALU stub: junk in the upper flag bits, and a stale OF=1 on SLT.
   always_comb begin
      logic [32:0] r;
      r      = alu_calc(alu_op, alu_a, alu_b);
      alu_f  = r[31:0];
      alu_zf = {31'h2AAA_AAAA, (r[31:0] == 32'd0)};
      alu_of = {31'h1555_5555, (alu_op == 3'd6) ? 1'b1 : r[32]};
   end

   function automatic logic [33:0] expect_resp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      r = alu_calc(op, a, b);
      return {(op == 3'd6) ? 1'b0 : r[32], (r[31:0] == 32'd0), r[31:0]};
   endfunction

   function automatic int pick(input bit v0, input bit v1, input bit last);
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         return 0;
`else
         return last ? 0 : 1;
`endif
      end
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = 1; m_in_resp = 0;
      m_op = 3'd0; m_a = 32'd0; m_b = 32'd0;
      exp_q.delete();
   endtask

   task automatic check_reset_vals();
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_resp0_valid", resp0_valid, 0);
      check("rst_resp1_valid", resp1_valid, 0);
      check("rst_resp_f", resp_f, 0);
      check("rst_resp_zf", resp_zf, 0);
      check("rst_resp_of", resp_of, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_state", dbg_state, 0);
   endtask

   // One clock: called just after a negedge with inputs set; checks, advances model, returns at next negedge.
   task automatic cycle();
      int g;
      bit rv, done;
      logic [33:0] e;
      #1;
      g  = m_busy ? -1 : pick(req0_valid, req1_valid, m_last);
      rv = m_busy && m_in_resp;
      check("req0_ready", req0_ready, g == 0);
      check("req1_ready", req1_ready, g == 1);
      check("resp0_valid", resp0_valid, rv && !m_owner);
      check("resp1_valid", resp1_valid, rv && m_owner);
      if (rv && exp_q.size() > 0) begin
         e = exp_q[0];
         check("resp_f", resp_f, e[31:0]);
         check("resp_zf", resp_zf, e[32]);
         check("resp_of", resp_of, e[33]);
      end
      check("alu_op", alu_op, m_op);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      acc0 = (g == 0);
      acc1 = (g == 1);
      done = rv && (m_owner ? resp1_ready : resp0_ready);
      @(posedge clk);
      if (g >= 0) begin
         m_busy = 1; m_in_resp = 0; m_owner = (g == 1); m_last = (g == 1);
         m_op = acc1 ? req1_op : req0_op;
         m_a  = acc1 ? req1_a  : req0_a;
         m_b  = acc1 ? req1_b  : req0_b;
         exp_q.push_back(expect_resp(m_op, m_a, m_b));
      end else if (m_busy) begin
         if (done) begin
            m_busy = 0; m_in_resp = 0;
            void'(exp_q.pop_front());
         end else begin
            m_in_resp = 1;
         end
      end
      @(negedge clk);
   endtask

   // Issue one op from an idle arbiter; returns at the negedge of the RESP cycle.
   task automatic run_op(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = (port == 0); req1_valid = (port == 1);
      req0_op = op; req0_a = a; req0_b = b;
      req1_op = op; req1_a = a; req1_b = b;
      resp0_ready = 1; resp1_ready = 1;
      cycle();
      req0_valid = 0; req1_valid = 0;
      cycle();
   endtask

   task automatic drain();
      req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
      repeat (3) cycle();
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         default: return $urandom_range(0, 31);
      endcase
   endfunction

   initial begin
      int n_g;
      int g_port[4];
      int g_cyc[4];
      rst_n = 0;
      req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      resp0_ready = 0; resp1_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst_n = 1;

      // Reset dropped mid-EXEC: outputs clear immediately, no response afterwards.
      req0_valid = 1; req0_op = 3'd4; req0_a = 32'd5; req0_b = 32'd7;
      cycle();
      rst_n = 0;
      #1;
      check_reset_vals();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1; req0_valid = 0; resp0_ready = 1; resp1_ready = 1;
      repeat (4) cycle();

      // Both ports valid continuously: grant order and acceptance spacing.
      req0_valid = 1; req0_op = 3'd0; req0_a = $urandom; req0_b = $urandom;
      req1_valid = 1; req1_op = 3'd1; req1_a = $urandom; req1_b = $urandom;
      n_g = 0;
      for (int k = 0; k < 4; k++) begin g_port[k] = -1; g_cyc[k] = -1; end
      for (int c = 0; c < 13; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            if (n_g < 4) begin g_port[n_g] = req1_ready ? 1 : 0; g_cyc[n_g] = c; end
            n_g++;
         end
         cycle();
      end
      check("rr_grant_count", n_g, 5);
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         check("rr_grant_port", g_port[k], 0);
`else
         check("rr_grant_port", g_port[k], k % 2);
`endif
      end
      for (int k = 0; k < 3; k++) check("rr_grant_gap", g_cyc[k+1] - g_cyc[k], 3);
      drain();

      // ADD overflow, then SLT with a stale OF from the ALU.
      run_op(0, 3'd4, 32'h7FFF_FFFF, 32'd1);
      #1;
      check("add_resp0_valid", resp0_valid, 1);
      check("add_f", resp_f, 32'h8000_0000);
      check("add_of", resp_of, 1);
      check("add_zf", resp_zf, 0);
      cycle();
      run_op(0, 3'd6, 32'd1, 32'd2);
      #1;
      check("slt_f", resp_f, 32'd1);
      check("slt_of", resp_of, 0);
      cycle();

      // SUB to zero on port 1.
      run_op(1, 3'd5, 32'h1234, 32'h1234);
      #1;
      check("sub_resp1_valid", resp1_valid, 1);
      check("sub_resp0_valid", resp0_valid, 0);
      check("sub_f", resp_f, 32'd0);
      check("sub_zf", resp_zf, 1);
      check("sub_of", resp_of, 0);
      cycle();

      // Backpressure on port 0 while port 1 waits.
      req0_valid = 1; req0_op = 3'd7; req0_a = 32'd4; req0_b = 32'd1;
      resp0_ready = 0; resp1_ready = 1;
      cycle();
      req0_valid = 0;
      req1_valid = 1; req1_op = 3'd4; req1_a = 32'd3; req1_b = 32'd9;
      repeat (11) cycle();
      #1;
      check("bp_resp0_valid", resp0_valid, 1);
      check("bp_f", resp_f, 32'h10);
      check("bp_req1_ready", req1_ready, 0);
      resp0_ready = 1;
      cycle();
      #1;
      check("bp_p1_accept", req1_ready, 1);
      cycle();
      req1_valid = 0;
      drain();

      // Randomized traffic; unaccepted requests are held unchanged.
      acc0 = 0; acc1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (acc0 || !req0_valid) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_op = 3'($urandom_range(0, 7)); req0_a = rand_operand(); req0_b = rand_operand();
         end
         if (acc1 || !req1_valid) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_op = 3'($urandom_range(0, 7)); req1_a = rand_operand(); req1_b = rand_operand();
         end
         resp0_ready = ($urandom_range(0, 3) != 0);
         resp1_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
